// File: rtl/mdu_pkg.sv
// +----------------------------------------------------------------------+
// | mdu_pkg : shared encodings and defaults for the multiply/divide unit |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package mdu_pkg;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // mndop[1] selects divide, mndop[0] selects unsigned
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mndop_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_MUL_RUN = 2'b01,
    ST_DIV_RUN = 2'b10
  } mdu_state_e;

endpackage

`default_nettype wire

// File: rtl/mdu_div.sv
// +----------------------------------------------------------------------+
// | mdu_div : combinational 32-bit signed/unsigned divider               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module mdu_div (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        signed_i,
  output logic [31:0] quot_o,
  output logic [31:0] rem_o
);

  logic        neg_a;
  logic        neg_b;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] divisor;
  logic [31:0] uquot;
  logic [31:0] urem;

  assign neg_a   = signed_i & a_i[31];
  assign neg_b   = signed_i & b_i[31];
  assign abs_a   = neg_a ? (32'd0 - a_i) : a_i;
  assign abs_b   = neg_b ? (32'd0 - b_i) : b_i;
  // Keep the core divider away from a zero divisor; that case is overridden below
  assign divisor = (b_i == 32'd0) ? 32'd1 : abs_b;
  assign uquot   = abs_a / divisor;
  assign urem    = abs_a % divisor;

  always_comb begin
    quot_o = (neg_a ^ neg_b) ? (32'd0 - uquot) : uquot;
    rem_o  = neg_a ? (32'd0 - urem) : urem;
    if (b_i == 32'd0) begin
      quot_o = 32'hFFFF_FFFF;
      rem_o  = a_i;
    end else if (signed_i && (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF)) begin
      quot_o = 32'h8000_0000;
      rem_o  = 32'd0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mult_div_unit.sv
// +----------------------------------------------------------------------+
// | mult_div_unit : multi-cycle MIPS-style HI/LO multiply/divide unit    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        mnd,
  input  logic [1:0]  mndop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        mnd_we,
  input  logic        hi_lo_sel,
  input  logic        Exception,
  output logic        Busy,
  output logic [31:0] hi_lo_result
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;

  logic [63:0]      mul_a;
  logic [63:0]      mul_b;
  logic [63:0]      product;
  logic [31:0]      div_quot;
  logic [31:0]      div_rem;

  // Extending both operands to 64 bits lets one product serve mult and multu
  assign mul_a   = {{32{~mndop[0] & A[31]}}, A};
  assign mul_b   = {{32{~mndop[0] & B[31]}}, B};
  assign product = mul_a * mul_b;

  mdu_div u_div (
    .a_i      (A),
    .b_i      (B),
    .signed_i (~mndop[0]),
    .quot_o   (div_quot),
    .rem_o    (div_rem)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    case (state_q)
      ST_IDLE: begin
        if (!Exception) begin
          if (mnd) begin
            if (mndop[1]) begin
              pend_hi_d = div_rem;
              pend_lo_d = div_quot;
              state_d   = ST_DIV_RUN;
              cnt_d     = CNT_W'(DIV_CYCLES - 1);
            end else begin
              pend_hi_d = product[63:32];
              pend_lo_d = product[31:0];
              state_d   = ST_MUL_RUN;
              cnt_d     = CNT_W'(MULT_CYCLES - 1);
            end
          end else if (mnd_we) begin
            if (hi_lo_sel) begin
              hi_d = A;
            end else begin
              lo_d = A;
            end
          end
        end
      end
      ST_MUL_RUN, ST_DIV_RUN: begin
        // Counter holds the remaining busy cycles minus one; zero marks the final cycle
        if (cnt_q == '0) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign Busy         = (state_q != ST_IDLE);
  assign hi_lo_result = hi_lo_sel ? hi_q : lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// +----------------------------------------------------------------------+
// | tb_mult_div_unit : scoreboard bench for mult_div_unit                |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mult_div_unit;

  logic        Clk;
  logic        Reset;
  logic        mnd;
  logic [1:0]  mndop;
  logic [31:0] A;
  logic [31:0] B;
  logic        mnd_we;
  logic        hi_lo_sel;
  logic        Exception;
  logic        Busy;
  logic [31:0] hi_lo_result;

  mult_div_unit #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .mnd          (mnd),
    .mndop        (mndop),
    .A            (A),
    .B            (B),
    .mnd_we       (mnd_we),
    .hi_lo_sel    (hi_lo_sel),
    .Exception    (Exception),
    .Busy         (Busy),
    .hi_lo_result (hi_lo_result)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    string       nm;
    logic [31:0] exp;
    bit          is_busy;
  } rd_t;

  rd_t  rd_q[$];
  int   len_q[$];
  int   errors = 0;
  int   checks = 0;
  logic mon_req = 1'b0;
  int   run_len = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  // Reference: results straight from the arithmetic definition of each op
  function automatic logic [63:0] ref_op(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    int              ia, ib;
    logic [31:0]     q, r;
    logic [63:0]     res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = a;
    ib = b;
    res = 64'd0;
    case (op)
      2'b00: res = sa * sb;
      2'b01: res = ua * ub;
      default: begin
        if (b == 32'd0) begin
          q = 32'hFFFF_FFFF; r = a;
        end else if (op == 2'b10 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          q = 32'h8000_0000; r = 32'd0;
        end else if (op == 2'b10) begin
          q = ia / ib; r = ia % ib;
        end else begin
          q = a / b; r = a % b;
        end
        res = {r, q};
      end
    endcase
    return res;
  endfunction

  always @(negedge Clk) begin
    if (!Reset) begin
      run_len = 0;
    end else if (Busy) begin
      run_len++;
    end else if (run_len != 0) begin
      checks++;
      if (len_q.size() == 0) begin
        errors++;
        $display("FAIL busy_len: unexpected run of %0d cycles, none required", run_len);
      end else begin
        int e;
        e = len_q.pop_front();
        if (e != run_len) begin
          errors++;
          $display("FAIL busy_len: got %0d cycles, required %0d", run_len, e);
        end
      end
      run_len = 0;
    end
    if (mon_req && rd_q.size() != 0) begin
      rd_t it;
      logic [31:0] act;
      it  = rd_q.pop_front();
      act = it.is_busy ? {31'd0, Busy} : hi_lo_result;
      checks++;
      if (act !== it.exp) begin
        errors++;
        $display("FAIL %s: got %h, required %h", it.nm, act, it.exp);
      end
    end
  end

  // All tasks start and end at posedge+1
  task automatic chk(input string nm, input logic sel, input logic [31:0] exp);
    hi_lo_sel = sel;
    rd_q.push_back('{nm, exp, 1'b0});
    mon_req = 1'b1;
    @(posedge Clk); #1;
    mon_req = 1'b0;
  endtask

  task automatic chk_busy(input string nm, input logic exp);
    rd_q.push_back('{nm, {31'd0, exp}, 1'b1});
    mon_req = 1'b1;
    @(posedge Clk); #1;
    mon_req = 1'b0;
  endtask

  task automatic chk_hilo(input string nm);
    chk({nm, "_hi"}, 1'b1, m_hi);
    chk({nm, "_lo"}, 1'b0, m_lo);
  endtask

  task automatic start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit expect_run);
    mnd = 1'b1; mndop = op; A = a; B = b;
    if (expect_run) len_q.push_back(op[1] ? 10 : 5);
    @(posedge Clk); #1;
    mnd = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (Busy && n < 40) begin
      @(posedge Clk); #1;
      n++;
    end
    if (Busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: Busy still %b after %0d cycles, required 0", Busy, n);
    end
  endtask

  task automatic do_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    logic [63:0] r;
    r = ref_op(op, a, b);
    start(op, a, b, 1'b1);
    wait_idle();
    {m_hi, m_lo} = r;
    chk_hilo(nm);
  endtask

  task automatic write_reg(input logic sel, input logic [31:0] v);
    mnd_we = 1'b1; hi_lo_sel = sel; A = v;
    @(posedge Clk); #1;
    mnd_we = 1'b0;
    if (sel) m_hi = v; else m_lo = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b0; mnd = 1'b0; mndop = 2'b00; A = 32'd0; B = 32'd0;
    mnd_we = 1'b0; hi_lo_sel = 1'b0; Exception = 1'b0;
    @(posedge Clk); #1;
    chk_busy("reset_busy", 1'b0);
    chk_hilo("reset");
    Reset = 1'b1;
    @(posedge Clk); #1;

    do_op("mult_neg2x3", 2'b00, 32'hFFFF_FFFE, 32'd3);
    do_op("divu_100_7", 2'b11, 32'd100, 32'd7);
    do_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2);
    do_op("div_by_0", 2'b10, 32'd5, 32'd0);
    do_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Writes and starts presented while busy are dropped
    start(2'b00, 32'd2, 32'd3, 1'b1);
    mnd_we = 1'b1; hi_lo_sel = 1'b0; A = 32'd9;
    @(posedge Clk); #1;
    mnd_we = 1'b0;
    start(2'b01, 32'd7, 32'd7, 1'b0);
    chk("busy_old_lo", 1'b0, m_lo);
    wait_idle();
    m_hi = 32'd0; m_lo = 32'd6;
    chk_hilo("ignore_busy");

    // Exception blocks a start and a write
    Exception = 1'b1;
    start(2'b11, 32'd50, 32'd3, 1'b0);
    chk_busy("exc_no_start", 1'b0);
    write_reg(1'b1, 32'hDEAD_BEEF);
    m_hi = 32'd0;
    Exception = 1'b0;
    chk_hilo("exc_block");

    // Start beats a simultaneous write
    mnd_we = 1'b1; hi_lo_sel = 1'b1;
    start(2'b01, 32'h10, 32'h10, 1'b1);
    mnd_we = 1'b0;
    wait_idle();
    m_hi = 32'd0; m_lo = 32'h100;
    chk_hilo("start_wins");

    write_reg(1'b1, 32'h1234_5678);
    write_reg(1'b0, 32'h9ABC_DEF0);
    chk_hilo("mtx");

    // Exception during a run does not abort it
    start(2'b10, 32'hFFFF_FF9C, 32'd7, 1'b1);
    Exception = 1'b1;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    Exception = 1'b0;
    wait_idle();
    {m_hi, m_lo} = ref_op(2'b10, 32'hFFFF_FF9C, 32'd7);
    chk_hilo("exc_in_run");

    // Reset mid-divide discards the pending result
    start(2'b11, 32'd1000, 32'd3, 1'b0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    chk_busy("rst_busy", 1'b0);
    chk_hilo("rst_mid");
    Reset = 1'b1;
    repeat (12) begin @(posedge Clk); #1; end
    chk_hilo("rst_no_commit");

    // First edge after release accepts a start
    Reset = 1'b0;
    @(posedge Clk); #1;
    Reset = 1'b1;
    do_op("post_rst", 2'b00, 32'd11, 32'd13);

    for (int i = 0; i < 24; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) write_reg(1'($urandom_range(0, 1)), $urandom);
      do_op("rand", op, a, b);
    end

    repeat (3) begin @(posedge Clk); #1; end
    checks++;
    if (len_q.size() != 0) begin
      errors++;
      $display("FAIL busy_pending: %0d runs never ended, required 0", len_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter MULT_CYCLES, default 5: Busy duration for mult/multu.
REQ-002 Parameter DIV_CYCLES, default 10: Busy duration for div/divu.
REQ-003 Clk  in  1  single clock, all state updates on rising edge.
REQ-004 Reset  in  1  asynchronous, active-low reset.
REQ-005 mnd  in  1  start strobe for a multiply/divide, EX stage.
REQ-006 mndop  in  2  operation select:
- 00 mult
- 01 multu
- 10 div
- 11 divu
REQ-007 A  in  32  rs operand, forwarded value.
REQ-008 B  in  32  rt operand, forwarded value.
REQ-009 mnd_we  in  1  mthi/mtlo write strobe.
REQ-010 hi_lo_sel  in  1  0 selects LO, 1 selects HI, for both reads and mnd_we writes.
REQ-011 Exception  in  1  flush of the instruction currently in EX.
REQ-012 Busy  out  1  operation in progress; hazard logic stalls mnd, mnd_we and mfhi/mflo while high.
REQ-013 hi_lo_result  out  32  selected HI/LO value, fed to the MEM pipe register.

Function
REQ-014 States SHALL be IDLE, MUL_RUN and DIV_RUN, with a cycle counter sized for max(MULT_CYCLES, DIV_CYCLES).
REQ-015 In IDLE, when mnd=1 and Exception=0 at edge T0, the block SHALL:
- capture the operands and the computed result into pending HI/LO registers;
- enter MUL_RUN (mndop[1]=0) or DIV_RUN (mndop[1]=1).
REQ-016 Busy SHALL be high from T0+ through the last cycle of the run:
- exactly MULT_CYCLES cycles for mult/multu;
- exactly DIV_CYCLES cycles for div/divu.
REQ-017 At the edge ending the run, HI/LO SHALL commit from the pending registers, Busy SHALL fall, and the state SHALL return to IDLE on that same edge.
REQ-018 mult/multu SHALL produce the full 64-bit signed/unsigned product: HI = bits 63:32, LO = bits 31:0.
REQ-019 div/divu SHALL truncate toward zero: LO = quotient, HI = remainder, remainder sign follows the dividend.
REQ-020 Divide by zero SHALL commit LO=32'hFFFF_FFFF and HI=A.
REQ-021 Signed 32'h8000_0000 / 32'hFFFF_FFFF SHALL commit LO=32'h8000_0000 and HI=0.
REQ-022 mnd_we in IDLE with Exception=0 SHALL write A into HI (hi_lo_sel=1) or LO (hi_lo_sel=0) at the next edge.
REQ-023 mnd and mnd_we both high in IDLE: the start SHALL win and the write SHALL be dropped.
REQ-024 mnd or mnd_we asserted while Busy=1 SHALL be ignored; the running operation is unaffected.
REQ-025 Exception=1 SHALL suppress a same-cycle start or write.
REQ-026 Exception during a run SHALL NOT abort it; the result still commits.
REQ-027 hi_lo_result SHALL be combinational: hi_lo_sel ? HI : LO of the committed registers. It shows old values while Busy=1.

Reset
REQ-028 Reset low SHALL immediately force, independent of Clk:
- state IDLE, counter 0, Busy=0;
- HI=0, LO=0, pending registers 0, hi_lo_result=0.
REQ-029 Reset asserted mid-run SHALL discard the pending result; no commit occurs after release.
REQ-030 The first edge after Reset deassertion SHALL accept a start normally.

Structure
REQ-031 A shared package mdu_pkg SHALL hold:
- the mndop encodings;
- the state encoding;
- the MULT_CYCLES and DIV_CYCLES defaults.
REQ-032 Signed/unsigned division SHALL live in sub-module mdu_div (quotient/remainder plus the REQ-020/021 special cases); the top holds the FSM, counter and HI/LO registers.
REQ-033 The multiplier SHALL be inferred inline in the top level.

Verification
REQ-034 mult A=32'hFFFF_FFFE (-2), B=3 -> Busy high 5 cycles, then HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFA.
REQ-035 divu A=100, B=7 -> Busy high 10 cycles, then LO=14, HI=2; div A=-7, B=2 -> LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF.
REQ-036 div A=5, B=0 -> LO=32'hFFFF_FFFF, HI=5.
REQ-037 Start mult 2*3; mnd_we (A=9, hi_lo_sel=0) in cycle 2 and a second mnd in cycle 3 -> both ignored; LO=6, HI=0 after 5 cycles.
REQ-038 mnd with Exception=1 -> Busy stays 0, HI/LO unchanged; mnd_we+mnd together in IDLE -> only the operation commits.
REQ-039 Reset pulsed low in cycle 3 of a div -> Busy=0 and HI=LO=0 immediately; no later commit.
